// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared opcodes, FSM encoding and helpers for the execute stage
//
// Purpose: 4-bit aluop encodings, multiply/divide FSM state encoding and the
//          is_muldiv() classifier shared by ex_stage_md and muldiv_iter.
// Ports:   none (package).

package ex_pkg;

  // Single-cycle ALU operations
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLL   = 4'h5;
  localparam logic [3:0] OP_SRL   = 4'h6;
  localparam logic [3:0] OP_SRA   = 4'h7;
  localparam logic [3:0] OP_SLT   = 4'h8;
  localparam logic [3:0] OP_SLTU  = 4'h9;

  // Iterative multiply/divide operations
  localparam logic [3:0] OP_MUL   = 4'hA;
  localparam logic [3:0] OP_MULHU = 4'hB;
  localparam logic [3:0] OP_DIV   = 4'hC;
  localparam logic [3:0] OP_DIVU  = 4'hD;
  localparam logic [3:0] OP_REM   = 4'hE;
  localparam logic [3:0] OP_REMU  = 4'hF;

  // Multiply/divide FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic is_muldiv(input logic [3:0] op);
    return op >= OP_MUL;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider
//
// Purpose: one multiply or divide step per cycle over N RUN cycles.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   en             pipeline advance; releases DONE back to IDLE
//   start          valid mul/div instruction present in EX
//   abort          kill the operation in flight (pipeline flush)
//   op             aluop of the instruction (A..F)
//   a, b           forwarded operands, latched on IDLE->RUN
//   busy           stall request: detect cycle or RUN
//   done           FSM in DONE, result valid
//   result         final, sign-corrected result

module muldiv_iter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         start,
  input  logic         abort,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);
  import ex_pkg::*;

  localparam int CW = $clog2(N);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  // hi:lo is the product for multiply, remainder:quotient for divide.
  // m_q is the multiplicand or the divisor magnitude.
  logic [N-1:0]  hi, lo, m_q;
  logic          qneg, rneg, dz;

  logic          op_div, op_sdiv, run_div;
  logic [N-1:0]  a_mag, b_mag;
  logic [N:0]    mul_sum, div_shift, div_diff;

  always_comb begin
    op_div    = op >= OP_DIV;
    op_sdiv   = (op == OP_DIV) || (op == OP_REM);
    a_mag     = (op_sdiv && a[N-1]) ? -a : a;
    b_mag     = (op_sdiv && b[N-1]) ? -b : b;
    run_div   = op_q >= OP_DIV;
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : {(N+1){1'b0}});
    div_shift = {hi, lo[N-1]};
    // Bit N set means the trial subtraction went negative: restore.
    div_diff  = div_shift - {1'b0, m_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
      m_q   <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      dz    <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            cnt   <= CW'(N - 1);
            op_q  <= op;
            hi    <= '0;
            lo    <= op_div ? a_mag : b;
            m_q   <= op_div ? b_mag : a;
            qneg  <= op_sdiv && (a[N-1] ^ b[N-1]);
            rneg  <= op_sdiv && a[N-1];
            dz    <= (b == '0);
          end
        end
        S_RUN: begin
          if (run_div) begin
            if (!div_diff[N]) begin
              hi <= div_diff[N-1:0];
              lo <= {lo[N-2:0], 1'b1};
            end else begin
              hi <= div_shift[N-1:0];
              lo <= {lo[N-2:0], 1'b0};
            end
          end else begin
            {hi, lo} <= {mul_sum, lo[N-1:1]};
          end
          if (cnt == '0) state <= S_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        S_DONE: begin
          if (en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sign fix-up happens here, on the magnitudes left by the datapath.
  // Divide-by-zero leaves quotient all ones and remainder = |dividend|,
  // so only the signed quotient needs an explicit override.
  always_comb begin
    case (op_q)
      OP_MULHU: result = hi;
      OP_DIV:   result = dz ? '1 : (qneg ? -lo : lo);
      OP_REM:   result = rneg ? -hi : hi;
      OP_REMU:  result = hi;
      default:  result = lo;
    endcase
  end

  assign busy = ((state == S_IDLE) && start) || (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - execute stage with forwarding, ALU and iterative mul/div
//
// Purpose: forwards rs1/rs2 from EX/MEM and MEM/WB, runs the single-cycle ALU
//          or muldiv_iter, and drives the EX/MEM pipeline register.
// Ports:
//   clk, rst, en, flush       clock, sync reset, pipeline advance, kill EX
//   id_*                      ID/EX control bits, aluop, data and addresses
//   wb_regwrite/rd_add/data   MEM/WB writeback path for forwarding
//   ex_busy                   stall request while mul/div occupies EX
//   exmem_*                   EX/MEM register outputs

module ex_stage_md #(
  parameter int N  = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          id_valid,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          id_alusrc,
  input  logic [3:0]    id_aluop,
  input  logic [N-1:0]  id_rs1_data,
  input  logic [N-1:0]  id_rs2_data,
  input  logic [N-1:0]  id_imm,
  input  logic [RA-1:0] id_rs1_add,
  input  logic [RA-1:0] id_rs2_add,
  input  logic [RA-1:0] id_rd_add,
  input  logic          wb_regwrite,
  input  logic [RA-1:0] wb_rd_add,
  input  logic [N-1:0]  wb_data,
  output logic          ex_busy,
  output logic          exmem_valid,
  output logic          exmem_regwrite,
  output logic          exmem_memread,
  output logic          exmem_memwrite,
  output logic          exmem_memtoreg,
  output logic [N-1:0]  exmem_result,
  output logic [N-1:0]  exmem_store_data,
  output logic [RA-1:0] exmem_rd_add
);
  import ex_pkg::*;

  localparam int SW = $clog2(N);

  logic [N-1:0]  fwd_rs1, fwd_rs2, op_a, op_b, alu_result, md_result;
  logic [SW-1:0] shamt;
  logic          md_done;

  // EX/MEM wins over MEM/WB because it holds the younger value.
  always_comb begin
    fwd_rs1 = id_rs1_data;
    if (exmem_valid && exmem_regwrite && (id_rs1_add != '0) && (id_rs1_add == exmem_rd_add))
      fwd_rs1 = exmem_result;
    else if (wb_regwrite && (id_rs1_add != '0) && (id_rs1_add == wb_rd_add))
      fwd_rs1 = wb_data;

    fwd_rs2 = id_rs2_data;
    if (exmem_valid && exmem_regwrite && (id_rs2_add != '0) && (id_rs2_add == exmem_rd_add))
      fwd_rs2 = exmem_result;
    else if (wb_regwrite && (id_rs2_add != '0) && (id_rs2_add == wb_rd_add))
      fwd_rs2 = wb_data;

    op_a  = fwd_rs1;
    op_b  = id_alusrc ? id_imm : fwd_rs2;
    shamt = op_b[SW-1:0];
  end

  always_comb begin
    case (id_aluop)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_SLL:  alu_result = op_a << shamt;
      OP_SRL:  alu_result = op_a >> shamt;
      OP_SRA:  alu_result = $signed(op_a) >>> shamt;
      OP_SLT:  alu_result = {{(N-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_result = {{(N-1){1'b0}}, (op_a < op_b)};
      default: alu_result = '0;
    endcase
  end

  muldiv_iter #(.N(N)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (id_valid && is_muldiv(id_aluop)),
    .abort  (flush),
    .op     (id_aluop),
    .a      (op_a),
    .b      (op_b),
    .busy   (ex_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      exmem_valid      <= 1'b0;
      exmem_regwrite   <= 1'b0;
      exmem_memread    <= 1'b0;
      exmem_memwrite   <= 1'b0;
      exmem_memtoreg   <= 1'b0;
      exmem_result     <= '0;
      exmem_store_data <= '0;
      exmem_rd_add     <= '0;
    end else if (flush || (en && ex_busy)) begin
      // Bubble: control cleared, data left as is.
      exmem_valid    <= 1'b0;
      exmem_regwrite <= 1'b0;
      exmem_memread  <= 1'b0;
      exmem_memwrite <= 1'b0;
      exmem_memtoreg <= 1'b0;
    end else if (en) begin
      exmem_valid      <= id_valid;
      exmem_regwrite   <= id_regwrite;
      exmem_memread    <= id_memread;
      exmem_memwrite   <= id_memwrite;
      exmem_memtoreg   <= id_memtoreg;
      exmem_result     <= md_done ? md_result : alu_result;
      exmem_store_data <= fwd_rs2;
      exmem_rd_add     <= id_rd_add;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - self-checking bench for ex_stage_md

module tb_ex_stage_md;
  localparam int N  = 32;
  localparam int RA = 5;

  logic          clk = 1'b0;
  logic          rst, en, flush;
  logic          id_valid, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
  logic [3:0]    id_aluop;
  logic [N-1:0]  id_rs1_data, id_rs2_data, id_imm;
  logic [RA-1:0] id_rs1_add, id_rs2_add, id_rd_add;
  logic          wb_regwrite;
  logic [RA-1:0] wb_rd_add;
  logic [N-1:0]  wb_data;
  logic          ex_busy, exmem_valid, exmem_regwrite, exmem_memread, exmem_memwrite, exmem_memtoreg;
  logic [N-1:0]  exmem_result, exmem_store_data;
  logic [RA-1:0] exmem_rd_add;

  int checks = 0;
  int errors = 0;

  // Expected EX/MEM contents
  logic          m_valid, m_regwrite, m_memread, m_memwrite, m_memtoreg;
  logic [31:0]   m_result, m_store;
  logic [4:0]    m_rd;

  ex_stage_md #(.N(N), .RA(RA)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .id_valid(id_valid), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1_add(id_rs1_add), .id_rs2_add(id_rs2_add),
    .id_rd_add(id_rd_add), .wb_regwrite(wb_regwrite), .wb_rd_add(wb_rd_add),
    .wb_data(wb_data), .ex_busy(ex_busy), .exmem_valid(exmem_valid),
    .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
    .exmem_memwrite(exmem_memwrite), .exmem_memtoreg(exmem_memtoreg),
    .exmem_result(exmem_result), .exmem_store_data(exmem_store_data),
    .exmem_rd_add(exmem_rd_add)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0; m_memtoreg = 0;
    m_result = 0; m_store = 0; m_rd = 0;
  endtask

  task automatic model_bubble();
    m_valid = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0; m_memtoreg = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"},    exmem_valid,    m_valid);
    check({tag, "_regwrite"}, exmem_regwrite, m_regwrite);
    check({tag, "_memread"},  exmem_memread,  m_memread);
    check({tag, "_memwrite"}, exmem_memwrite, m_memwrite);
    check({tag, "_memtoreg"}, exmem_memtoreg, m_memtoreg);
    if (m_valid) begin
      check({tag, "_result"}, exmem_result,     m_result);
      check({tag, "_store"},  exmem_store_data, m_store);
      check({tag, "_rd"},     exmem_rd_add,     m_rd);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] data);
    if (m_valid && m_regwrite && addr != 0 && addr == m_rd) return m_result;
    if (wb_regwrite && addr != 0 && addr == wb_rd_add) return wb_data;
    return data;
  endfunction

  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    logic [4:0] sh;
    sa = a; sb = b; sh = b[4:0];
    p = {32'h0, a} * {32'h0, b};
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << sh;
      4'h6: return a >> sh;
      4'h7: return 32'(sa >>> sh);
      4'h8: return (sa < sb) ? 32'd1 : 32'd0;
      4'h9: return (a < b) ? 32'd1 : 32'd0;
      4'hA: return p[31:0];
      4'hB: return p[63:32];
      4'hC: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      4'hD: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hE: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one instruction with en high and retire it into EX/MEM.
  // hold = number of en=0 cycles (before issue for single-cycle ops,
  // in DONE for mul/div ops).
  task automatic run_instr(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic alusrc, input logic rw, input int hold);
    logic [31:0] a, b, exp, sd;
    logic mr, mw, mt;
    int cyc;
    mr = 1'($urandom_range(0, 1));
    mw = 1'($urandom_range(0, 1));
    mt = 1'($urandom_range(0, 1));
    id_valid = 1; id_aluop = op; id_rs1_add = r1; id_rs2_add = r2; id_rd_add = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alusrc = alusrc;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mt;
    en = 1; flush = 0;
    a   = fwd(r1, d1);
    sd  = fwd(r2, d2);
    b   = alusrc ? imm : sd;
    exp = ref_op(op, a, b);
    #1;
    if (op < 4'hA) begin
      check("busy_single", ex_busy, 0);
      for (int i = 0; i < hold; i++) begin
        en = 0;
        step();
        check_model("hold_single");
      end
      en = 1;
      step();
    end else begin
      check("busy_start", ex_busy, 1);
      cyc = 0;
      while (ex_busy && cyc < 100) begin
        step();
        cyc++;
        model_bubble();
        check("busy_bubble", exmem_valid, 0);
        // Disturb the forwarding paths; latched operands must not care.
        wb_regwrite = 1;
        wb_rd_add   = $urandom_range(0, 1) ? r1 : r2;
        wb_data     = $urandom;
        #1;
      end
      check("busy_len", 32'(cyc), 32'(N + 1));
      for (int i = 0; i < hold; i++) begin
        en = 0;
        step();
        check("done_hold_valid", exmem_valid, 0);
        check("done_hold_busy", ex_busy, 0);
      end
      en = 1;
      sd = fwd(r2, d2);
      step();
    end
    m_valid = 1; m_regwrite = rw; m_memread = mr; m_memwrite = mw; m_memtoreg = mt;
    m_result = exp; m_store = sd; m_rd = rd;
    check_model("retire");
  endtask

  initial begin
    rst = 1; en = 0; flush = 0;
    id_valid = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0; id_alusrc = 0;
    id_aluop = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_add = 0; id_rs2_add = 0; id_rd_add = 0;
    wb_regwrite = 0; wb_rd_add = 0; wb_data = 0;
    model_reset();
    step();
    step();
    check("rst_busy", ex_busy, 0);
    check("rst_valid", exmem_valid, 0);
    check("rst_regwrite", exmem_regwrite, 0);
    check("rst_memread", exmem_memread, 0);
    check("rst_memwrite", exmem_memwrite, 0);
    check("rst_memtoreg", exmem_memtoreg, 0);
    check("rst_result", exmem_result, 0);
    check("rst_store", exmem_store_data, 0);
    check("rst_rd", exmem_rd_add, 0);
    rst = 0;

    // x5 = 7, then ADD x6, x5, 3 via EX/MEM forwarding
    run_instr(4'h0, 5'd0, 5'd0, 5'd5, 32'd7, 32'd0, 32'd0, 1'b1, 1'b1, 0);
    run_instr(4'h0, 5'd5, 5'd0, 5'd6, 32'd99, 32'd0, 32'd3, 1'b1, 1'b1, 0);
    check("fwd_exmem_add", exmem_result, 32'd10);

    // EX/MEM x5 = 1 beats WB x5 = 2
    run_instr(4'h0, 5'd0, 5'd0, 5'd5, 32'd1, 32'd0, 32'd0, 1'b1, 1'b1, 0);
    wb_regwrite = 1; wb_rd_add = 5'd5; wb_data = 32'd2;
    run_instr(4'h0, 5'd5, 5'd5, 5'd7, 32'd50, 32'd60, 32'd0, 1'b0, 1'b1, 0);
    check("fwd_priority", exmem_result, 32'd2);
    // x0 is never forwarded
    run_instr(4'h0, 5'd0, 5'd0, 5'd0, 32'd5, 32'd0, 32'd0, 1'b1, 1'b1, 0);
    wb_rd_add = 5'd0; wb_data = 32'd1000;
    run_instr(4'h0, 5'd0, 5'd0, 5'd8, 32'd11, 32'd22, 32'd0, 1'b0, 1'b1, 0);
    check("fwd_x0", exmem_result, 32'd33);
    wb_regwrite = 0;

    run_instr(4'hA, 5'd0, 5'd0, 5'd9, 32'h0000_FFFF, 32'd0, 32'h0001_0001, 1'b1, 1'b1, 0);
    check("mul", exmem_result, 32'hFFFF_FFFF);
    wb_regwrite = 0;
    run_instr(4'hC, 5'd0, 5'd0, 5'd9, 32'hFFFF_FFF9, 32'd0, 32'd2, 1'b1, 1'b1, 0);
    check("div_neg", exmem_result, 32'hFFFF_FFFD);
    wb_regwrite = 0;
    run_instr(4'hE, 5'd0, 5'd0, 5'd9, 32'hFFFF_FFF9, 32'd0, 32'd2, 1'b1, 1'b1, 0);
    check("rem_neg", exmem_result, 32'hFFFF_FFFF);
    wb_regwrite = 0;
    run_instr(4'hD, 5'd0, 5'd0, 5'd9, 32'd123, 32'd0, 32'd0, 1'b1, 1'b1, 0);
    check("divu_zero", exmem_result, 32'hFFFF_FFFF);
    wb_regwrite = 0;
    run_instr(4'hE, 5'd0, 5'd0, 5'd9, 32'hFFFF_FFF9, 32'd0, 32'd0, 1'b1, 1'b1, 0);
    check("rem_zero", exmem_result, 32'hFFFF_FFF9);
    wb_regwrite = 0;
    run_instr(4'hC, 5'd0, 5'd0, 5'd9, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
    check("div_ovf", exmem_result, 32'h8000_0000);
    wb_regwrite = 0;
    // en low for 3 cycles in DONE
    run_instr(4'hB, 5'd0, 5'd0, 5'd9, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 3);
    check("mulhu_hold", exmem_result, 32'hFFFF_FFFE);
    wb_regwrite = 0;

    // flush mid-RUN
    id_valid = 1; id_aluop = 4'hA; id_rs1_add = 0; id_rs2_add = 0; id_alusrc = 1;
    id_rs1_data = 32'd3; id_imm = 32'd5; id_regwrite = 1; en = 1; flush = 0;
    repeat (5) step();
    flush = 1;
    step();
    flush = 0; id_valid = 0;
    #1;
    model_bubble();
    check("flush_busy", ex_busy, 0);
    check("flush_valid", exmem_valid, 0);
    check("flush_regwrite", exmem_regwrite, 0);
    run_instr(4'h0, 5'd0, 5'd0, 5'd4, 32'd40, 32'd0, 32'd2, 1'b1, 1'b1, 0);
    check("after_flush_add", exmem_result, 32'd42);

    // reset mid-RUN
    run_instr(4'h0, 5'd0, 5'd0, 5'd4, 32'd1, 32'd0, 32'd1, 1'b1, 1'b1, 0);
    id_valid = 1; id_aluop = 4'hC; id_rs1_data = 32'd100; id_imm = 32'd7; id_alusrc = 1;
    repeat (10) step();
    rst = 1;
    step();
    rst = 0; id_valid = 0;
    #1;
    model_reset();
    check("rstrun_busy", ex_busy, 0);
    check("rstrun_valid", exmem_valid, 0);
    check("rstrun_regwrite", exmem_regwrite, 0);
    check("rstrun_result", exmem_result, 0);
    check("rstrun_store", exmem_store_data, 0);
    check("rstrun_rd", exmem_rd_add, 0);

    for (int k = 0; k < 150; k++) begin
      logic [3:0] op;
      int hold;
      wb_regwrite = 1'($urandom_range(0, 1));
      wb_rd_add   = 5'($urandom_range(0, 3));
      wb_data     = rnd();
      op   = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage for the five-stage RISC-V pipeline.
- Forwards operands from EX/MEM and MEM/WB, then runs a single-cycle ALU or an iterative RV32M-subset multiply/divide unit.
- Drives the EX/MEM pipeline register, including valid and control bits.
- Sits between the ID/EX register and the memory stage.
- Raises `ex_busy` to the hazard unit while a multi-cycle operation occupies EX.

## Interface
Parameters:
- `N`, 32: data width; even, at least 8.
- `RA`, 5: register-address width.

Ports (name, direction, width, meaning):
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: pipeline advance from the hazard unit; EX/MEM loads only when high.
- `flush`  in  1: kill the instruction in EX.
- `id_valid, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc`  in  1 each: ID/EX control bits.
- `id_aluop`  in  4: operation code.
- `id_rs1_data, id_rs2_data, id_imm`  in  N: ID/EX data.
- `id_rs1_add, id_rs2_add, id_rd_add`  in  RA: ID/EX register addresses.
- `wb_regwrite`  in  1, `wb_rd_add`  in  RA, `wb_data`  in  N: MEM/WB writeback path.
- `ex_busy`  out  1: stall request to the hazard unit.
- `exmem_valid, exmem_regwrite, exmem_memread, exmem_memwrite, exmem_memtoreg`  out  1 each: EX/MEM control.
- `exmem_result, exmem_store_data`  out  N: EX/MEM data.
- `exmem_rd_add`  out  RA: EX/MEM destination address.

## Operation
- Opcodes 0–9, single-cycle: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Shift amount is the low log2(N) bits of operand B.
- Opcodes A–F, multi-cycle: MUL (low N bits), MULHU, DIV, DIVU, REM, REMU.
- Forwarding per source operand, applied independently to rs1 and rs2:
  - If `exmem_valid & exmem_regwrite`, the address is nonzero and matches, take `exmem_result`.
  - Otherwise, if `wb_regwrite` is set, the address is nonzero and matches, take `wb_data`.
  - Otherwise take the ID/EX data.
- Operand A = forwarded rs1.
- Operand B = `id_imm` if `id_alusrc`, else forwarded rs2.
- `exmem_store_data` always takes forwarded rs2.
- Multiply/divide FSM, states IDLE, RUN, DONE:
  - IDLE → RUN when `id_valid` and opcode ≥ A. Forwarded operands are latched and a step counter is loaded with N−1.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. RUN → DONE when the counter reaches 0.
  - DONE → IDLE on a cycle with `en`=1; the result is captured into EX/MEM on that edge. With `en`=0, DONE holds the result.
- Signed divide: the unit operates on magnitudes and fixes signs in DONE.
- Divide-by-zero: quotient = all ones, remainder = dividend.
- Signed overflow (min ÷ −1): quotient = min, remainder = 0.
- `ex_busy` = (IDLE & `id_valid` & opcode ≥ A) | RUN. It is combinational and low in DONE.
- While `ex_busy`=1 and `en`=1, EX/MEM loads a bubble: valid and all control bits 0, data don't-care.

## Timing
- Reset: FSM in IDLE; every `exmem_*` output 0; `ex_busy` 0 once the reset cycle completes.
- Single-cycle op: result appears in `exmem_result` one edge after the cycle where `en`=1.
- Multi-cycle op: in EX for N+2 cycles (detect, N RUN cycles, DONE) when `en` stays high. The result is visible one edge after DONE.
- `en`=0 with no busy condition: all EX/MEM outputs hold.
- `flush`=1: EX/MEM loads a bubble regardless of `en`, and the FSM returns to IDLE, aborting a RUN. `flush` overrides busy and `en`.
- `rst` overrides everything, including mid-RUN.
- Operands latched at IDLE→RUN are immune to later changes on the WB or EX/MEM paths during RUN.

## Structure
- Package `ex_pkg`: 4-bit aluop codes as localparams, FSM state encoding, and an `is_muldiv(op)` function.
- Sub-module `muldiv_iter`: FSM, counter, and the iterative datapath. It exposes `start`, `abort`, `op`, `a`, `b`, `busy`, `done`, `result`.
- Forwarding muxes, ALU, and the EX/MEM register stay in the top level.

## Test plan
- ADD with EX/MEM forwarding: prior instruction writes x5 = 7; ADD x6, x5, imm 3 → `exmem_result` = 10 next edge.
- MEM/WB priority: both paths target x5, EX/MEM holds 1 and WB holds 2 → operand = 1. With x0 as target, no forwarding occurs.
- MUL, N=32: 0xFFFF × 0x10001 → `ex_busy` high 33 cycles, then `exmem_result` = 0xFFFFFFFF. EX/MEM valid is 0 during busy.
- DIV: −7 ÷ 2 → −3; REM → −1. DIVU by 0 → 0xFFFFFFFF. REM by 0 → dividend. DIV 0x80000000 ÷ −1 → 0x80000000.
- `flush` asserted mid-RUN → FSM back in IDLE and `ex_busy` low next cycle; EX/MEM bubble. A following ADD completes normally.
- `en`=0 held in DONE for 3 cycles → result held, then captured on the first edge with `en`=1. `rst` mid-RUN → all outputs 0.
